audio_codec_target: RTL and testbench

//  Codec-side (target) end of the audio serial link: BCLK/LRCK are inputs from the FPGA-side master.

---
 rtl/audio_pkg.sv | 14 +
 rtl/audio_if.sv | 27 ++
 rtl/audio_pad_sync.sv | 47 ++++
 rtl/audio_codec_target.sv | 151 +++++++++++++++
 tb/tb_audio_codec_target.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/audio_pkg.sv
// Shared definitions for the codec-side audio serial link.
//   DEFAULT_DATA_W : default sample width (bits per channel slot)
//   CH_LEFT/RIGHT  : channel codes used on rx_chan / tx_chan
//   sample_t       : one sample at the default width
package audio_pkg;

    localparam int DEFAULT_DATA_W = 16;

    localparam logic CH_LEFT  = 1'b1;
    localparam logic CH_RIGHT = 1'b0;

    typedef logic [DEFAULT_DATA_W-1:0] sample_t;

endpackage

// File: rtl/audio_if.sv
// Audio serial link pins between the FPGA-side master and the codec-side target.
//   AUD_BCLK   : bit clock, driven by master
//   AUD_LRCK   : frame clock (DACLRCK/ADCLRCK tied), driven by master
//   AUD_DACDAT : playback serial data, driven by master
//   AUD_ADCDAT : capture serial data, driven by target
interface audio_if;

    logic AUD_BCLK;
    logic AUD_LRCK;
    logic AUD_DACDAT;
    logic AUD_ADCDAT;

    modport master (
        output AUD_BCLK,
        output AUD_LRCK,
        output AUD_DACDAT,
        input  AUD_ADCDAT
    );

    modport slave (
        input  AUD_BCLK,
        input  AUD_LRCK,
        input  AUD_DACDAT,
        output AUD_ADCDAT
    );

endinterface

// File: rtl/audio_pad_sync.sv
// Pad synchroniser with edge detection.
//   clk, reset : system clock, asynchronous active-low reset
//   pad        : asynchronous input pin
//   sync       : pad value after SYNC_STAGES flops
//   rise, fall : one-clk pulses on edges of sync
// Edge pulses appear SYNC_STAGES+1 clk after the pad changes.
module audio_pad_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic pad,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;
    logic [SYNC_STAGES:0]   fill;

    // Synchroniser chain, previous-value flop, and a fill marker that tells us
    // when prev holds a genuinely sampled pad value. Without the marker a pad
    // sitting high at reset release would look like a rising edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chain <= '0;
            prev  <= 1'b0;
            fill  <= '0;
        end else begin
            for (int i = SYNC_STAGES - 1; i > 0; i--) begin
                chain[i] <= chain[i-1];
            end
            chain[0] <= pad;
            prev     <= chain[SYNC_STAGES-1];
            for (int i = SYNC_STAGES; i > 0; i--) begin
                fill[i] <= fill[i-1];
            end
            fill[0] <= 1'b1;
        end
    end

    assign sync = chain[SYNC_STAGES-1];
    assign rise = fill[SYNC_STAGES] & sync & ~prev;
    assign fall = fill[SYNC_STAGES] & ~sync & prev;

endmodule

// File: rtl/audio_codec_target.sv
// Codec-side (target) end of a left-justified audio serial link.
// BCLK/LRCK come from the master; DACDAT is deserialised into playback
// samples and capture samples are serialised onto ADCDAT, MSB first.
//   clk, reset          : system clock, asynchronous active-low reset
//   aud                 : serial pins (slave modport)
//   rx_data/chan/valid  : last complete playback sample, its channel, new-pulse
//   tx_data/chan/valid  : capture sample offered for a channel
//   tx_ready[1:0]       : [1] left, [0] right holding register empty
//   tx_req[1:0]         : pulse when that channel's holding register is consumed
//   frame_err           : pulse when LRCK toggled before a full sample arrived
//   underrun            : pulse when a slot started with an empty holding register
module audio_codec_target
    import audio_pkg::*;
#(
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int SYNC_STAGES = 2,
    parameter bit LEFT_LVL    = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    audio_if.slave            aud,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_chan,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_chan,
    input  logic              tx_valid,
    output logic [1:0]        tx_ready,
    output logic [1:0]        tx_req,
    output logic              frame_err,
    output logic              underrun
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic bclk_rise, bclk_fall;
    logic lrck_s, lrck_rise, lrck_fall, lrck_edge;
    logic dacdat_s;
    logic [1:0] dacdat_unused;

    audio_pad_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_bclk (
        .clk(clk), .reset(reset), .pad(aud.AUD_BCLK),
        .sync(), .rise(bclk_rise), .fall(bclk_fall)
    );

    audio_pad_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lrck (
        .clk(clk), .reset(reset), .pad(aud.AUD_LRCK),
        .sync(lrck_s), .rise(lrck_rise), .fall(lrck_fall)
    );

    audio_pad_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dacdat (
        .clk(clk), .reset(reset), .pad(aud.AUD_DACDAT),
        .sync(dacdat_s), .rise(dacdat_unused[1]), .fall(dacdat_unused[0])
    );

    assign lrck_edge = lrck_rise | lrck_fall;

    logic              chan;
    logic              slot_active;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-2:0] rx_sh;
    logic [DATA_W-1:0] tx_sh;
    logic [DATA_W-1:0] hold [2];
    logic              adcdat_q;

    logic       new_chan;
    logic [1:0] xfer;
    logic [1:0] take;

    // Channel of the slot that starts on this LRCK edge, the handshake
    // transfers into each holding register, and which full holding register
    // (if any) the starting slot consumes.
    assign new_chan = (lrck_s == LEFT_LVL);
    assign xfer[1]  = tx_valid & (tx_chan == CH_LEFT)  & tx_ready[1];
    assign xfer[0]  = tx_valid & (tx_chan == CH_RIGHT) & tx_ready[0];
    assign take     = lrck_edge ? ((new_chan ? 2'b10 : 2'b01) & ~tx_ready) : 2'b00;

    // Slot control and both shifters. An LRCK edge starts a new slot and wins
    // over any BCLK event in the same cycle. slot_active stays low after reset
    // until the first real LRCK edge, so a slot interrupted by reset is dropped
    // without a frame error and without a bogus rx_valid.
    // Holding register contents are never cleared on consume: an empty
    // register still holds the last sample sent, which is what gets repeated
    // on underrun.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chan        <= 1'b0;
            slot_active <= 1'b0;
            bit_cnt     <= '0;
            rx_sh       <= '0;
            tx_sh       <= '0;
            hold[0]     <= '0;
            hold[1]     <= '0;
            adcdat_q    <= 1'b0;
            rx_data     <= '0;
            rx_chan     <= 1'b0;
            rx_valid    <= 1'b0;
            tx_ready    <= 2'b11;
            tx_req      <= 2'b00;
            frame_err   <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            underrun  <= 1'b0;
            tx_req    <= take;
            adcdat_q  <= tx_sh[DATA_W-1];
            tx_ready  <= (tx_ready | take) & ~xfer;
            if (xfer[0]) hold[0] <= tx_data;
            if (xfer[1]) hold[1] <= tx_data;

            if (lrck_edge) begin
                chan        <= new_chan;
                slot_active <= 1'b1;
                bit_cnt     <= '0;
                tx_sh       <= hold[new_chan];
                if (slot_active && bit_cnt != '0 && bit_cnt < CNT_FULL) begin
                    frame_err <= 1'b1;
                end
                if (tx_ready[new_chan]) begin
                    underrun <= 1'b1;
                end
            end else if (slot_active) begin
                if (bclk_rise && bit_cnt < CNT_FULL) begin
                    rx_sh   <= {rx_sh[DATA_W-3:0], dacdat_s};
                    bit_cnt <= bit_cnt + CNT_ONE;
                    if (bit_cnt == CNT_LAST) begin
                        rx_data  <= {rx_sh, dacdat_s};
                        rx_chan  <= chan;
                        rx_valid <= 1'b1;
                    end
                end
                // The last data bit is held until the fall after it, then the
                // line is forced low for the padding BCLKs.
                if (bclk_fall) begin
                    if (bit_cnt != '0 && bit_cnt < CNT_FULL) begin
                        tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};
                    end else if (bit_cnt == CNT_FULL) begin
                        tx_sh <= '0;
                    end
                end
            end
        end
    end

    assign aud.AUD_ADCDAT = adcdat_q;

endmodule

// File: tb/tb_audio_codec_target.sv
// Directed bench for audio_codec_target: a BFM master drives BCLK (16 clk
// period), LRCK (32 BCLK per phase) and DACDAT, and samples ADCDAT on BCLK
// rise. A monitor logs rx samples, tx_req pulses, frame errors and underruns.
module tb_audio_codec_target;
    import audio_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    sample_t     rx_data;
    logic        rx_chan;
    logic        rx_valid;
    sample_t     tx_data;
    logic        tx_chan;
    logic        tx_valid;
    logic [1:0]  tx_ready;
    logic [1:0]  tx_req;
    logic        frame_err;
    logic        underrun;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [16:0] rx_q  [$];
    logic [1:0]  req_q [$];
    int          ferr_cnt = 0;
    int          urun_cnt = 0;

    audio_if bus ();

    audio_codec_target #(
        .DATA_W(16), .SYNC_STAGES(2), .LEFT_LVL(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .aud(bus),
        .rx_data(rx_data), .rx_chan(rx_chan), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_chan(tx_chan), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_req(tx_req),
        .frame_err(frame_err), .underrun(underrun)
    );

    always #5 clk = ~clk;

    // Event monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (reset) begin
            if (rx_valid) rx_q.push_back({rx_chan, rx_data});
            if (tx_req != 2'b00) req_q.push_back(tx_req);
            if (frame_err) ferr_cnt = ferr_cnt + 1;
            if (underrun) urun_cnt = urun_cnt + 1;
        end
    end

    // One LRCK phase of nbits BCLKs; LRCK is set with the first BCLK fall.
    task automatic send_slot(input logic lvl, input logic [15:0] dac, input int nbits,
                             output logic [15:0] adc, output logic pad_ok);
        adc    = '0;
        pad_ok = 1'b1;
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            bus.AUD_BCLK = 1'b0;
            if (i == 0) bus.AUD_LRCK = lvl;
            bus.AUD_DACDAT = (i < 16) ? dac[15-i] : 1'b0;
            repeat (8) @(negedge clk);
            bus.AUD_BCLK = 1'b1;
            if (i < 16) adc[15-i] = bus.AUD_ADCDAT;
            else if (bus.AUD_ADCDAT !== 1'b0) pad_ok = 1'b0;
            repeat (7) @(negedge clk);
        end
    endtask

    task automatic push(input logic ch, input logic [15:0] d);
        @(negedge clk);
        tests_run++;
        if (tx_ready[ch] !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL push_ready ch=%0d got %b want 1", ch, tx_ready[ch]);
        end
        tx_valid = 1'b1;
        tx_chan  = ch;
        tx_data  = d;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] adc;
        logic        ok;
        int          rx0;
        int          fe0;
        tests_run++;
        if (bus.AUD_ADCDAT !== 1'b0 || rx_valid !== 1'b0 || tx_ready !== 2'b11 ||
            tx_req !== 2'b00 || frame_err !== 1'b0 || underrun !== 1'b0 || rx_data !== 16'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_values adc=%b rxv=%b rdy=%b req=%b fe=%b ur=%b rxd=%h want 0 0 11 00 0 0 0000",
                     bus.AUD_ADCDAT, rx_valid, tx_ready, tx_req, frame_err, underrun, rx_data);
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        push(CH_RIGHT, 16'h5555);
        tests_run++;
        if (tx_ready !== 2'b10) begin
            tests_failed++;
            $display("[TB] FAIL ready_after_push got %b want 10", tx_ready);
        end
        send_slot(1'b1, 16'hFFFF, 8, adc, ok);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (bus.AUD_ADCDAT !== 1'b0 || rx_valid !== 1'b0 || tx_ready !== 2'b11) begin
            tests_failed++;
            $display("[TB] FAIL midframe_reset adc=%b rxv=%b rdy=%b want 0 0 11",
                     bus.AUD_ADCDAT, rx_valid, tx_ready);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        rx0 = rx_q.size();
        fe0 = ferr_cnt;
        send_slot(1'b1, 16'hFFFF, 24, adc, ok);
        tests_run++;
        if (rx_q.size() != rx0) begin
            tests_failed++;
            $display("[TB] FAIL no_rx_before_edge got %0d samples want 0", rx_q.size() - rx0);
        end
        send_slot(1'b0, 16'h0F0F, 32, adc, ok);
        tests_run++;
        if (rx_q.size() != rx0 + 1 || rx_q[rx0] !== {1'b0, 16'h0F0F}) begin
            tests_failed++;
            $display("[TB] FAIL first_rx_after_reset count=%0d want 1, value want 0_0f0f",
                     rx_q.size() - rx0);
        end
        tests_run++;
        if (ferr_cnt != fe0) begin
            tests_failed++;
            $display("[TB] FAIL reset_no_frame_err got %0d want 0", ferr_cnt - fe0);
        end
    endtask

    task automatic test_playback();
        logic [15:0] adc;
        logic        ok;
        int          rx0;
        rx0 = rx_q.size();
        send_slot(1'b1, 16'hA55A, 32, adc, ok);
        send_slot(1'b0, 16'h0F0F, 32, adc, ok);
        tests_run++;
        if (rx_q.size() != rx0 + 2) begin
            tests_failed++;
            $display("[TB] FAIL playback_count got %0d want 2", rx_q.size() - rx0);
        end else begin
            tests_run++;
            if (rx_q[rx0] !== {1'b1, 16'hA55A}) begin
                tests_failed++;
                $display("[TB] FAIL playback_left got %h want 1a55a", rx_q[rx0]);
            end
            tests_run++;
            if (rx_q[rx0+1] !== {1'b0, 16'h0F0F}) begin
                tests_failed++;
                $display("[TB] FAIL playback_right got %h want 00f0f", rx_q[rx0+1]);
            end
        end
    endtask

    task automatic test_capture();
        logic [15:0] adc_l, adc_r;
        logic        ok_l, ok_r;
        int          rq0;
        int          ur0;
        rq0 = req_q.size();
        ur0 = urun_cnt;
        push(CH_LEFT, 16'h8001);
        push(CH_RIGHT, 16'h7FFE);
        tests_run++;
        if (tx_ready !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL capture_ready_full got %b want 00", tx_ready);
        end
        send_slot(1'b1, 16'h0000, 32, adc_l, ok_l);
        send_slot(1'b0, 16'h0000, 32, adc_r, ok_r);
        tests_run++;
        if (adc_l !== 16'h8001) begin
            tests_failed++;
            $display("[TB] FAIL capture_left got %h want 8001", adc_l);
        end
        tests_run++;
        if (adc_r !== 16'h7FFE) begin
            tests_failed++;
            $display("[TB] FAIL capture_right got %h want 7ffe", adc_r);
        end
        tests_run++;
        if (ok_l !== 1'b1 || ok_r !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL capture_padding_zero got %b%b want 11", ok_l, ok_r);
        end
        tests_run++;
        if (req_q.size() != rq0 + 2 || req_q[rq0] !== 2'b10 || req_q[rq0+1] !== 2'b01) begin
            tests_failed++;
            $display("[TB] FAIL capture_tx_req count=%0d want 2 pulses 10 then 01", req_q.size() - rq0);
        end
        tests_run++;
        if (urun_cnt != ur0 || tx_ready !== 2'b11) begin
            tests_failed++;
            $display("[TB] FAIL capture_underrun_ready ur=%0d rdy=%b want 0 11", urun_cnt - ur0, tx_ready);
        end
    endtask

    task automatic test_underrun();
        logic [15:0] l1, r1, l2, r2;
        logic        ok;
        int          rq0;
        int          ur0;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        rq0 = req_q.size();
        ur0 = urun_cnt;
        push(CH_LEFT, 16'h1234);
        send_slot(1'b1, 16'h0000, 32, l1, ok);
        send_slot(1'b0, 16'h0000, 32, r1, ok);
        send_slot(1'b1, 16'h0000, 32, l2, ok);
        send_slot(1'b0, 16'h0000, 32, r2, ok);
        tests_run++;
        if (l1 !== 16'h1234 || l2 !== 16'h1234) begin
            tests_failed++;
            $display("[TB] FAIL underrun_left_repeat got %h %h want 1234 1234", l1, l2);
        end
        tests_run++;
        if (r1 !== 16'h0000 || r2 !== 16'h0000) begin
            tests_failed++;
            $display("[TB] FAIL underrun_right_zero got %h %h want 0000 0000", r1, r2);
        end
        tests_run++;
        if (urun_cnt - ur0 != 3) begin
            tests_failed++;
            $display("[TB] FAIL underrun_pulses got %0d want 3", urun_cnt - ur0);
        end
        tests_run++;
        if (req_q.size() != rq0 + 1 || req_q[rq0] !== 2'b10) begin
            tests_failed++;
            $display("[TB] FAIL underrun_tx_req count=%0d want 1 pulse 10", req_q.size() - rq0);
        end
    endtask

    task automatic test_short_slot();
        logic [15:0] adc;
        logic        ok;
        int          rx0;
        int          fe0;
        rx0 = rx_q.size();
        fe0 = ferr_cnt;
        send_slot(1'b1, 16'hFFFF, 9, adc, ok);
        send_slot(1'b0, 16'h3C3C, 32, adc, ok);
        tests_run++;
        if (ferr_cnt - fe0 != 1) begin
            tests_failed++;
            $display("[TB] FAIL short_frame_err got %0d want 1", ferr_cnt - fe0);
        end
        tests_run++;
        if (rx_q.size() != rx0 + 1 || rx_q[rx0] !== {1'b0, 16'h3C3C}) begin
            tests_failed++;
            $display("[TB] FAIL short_rx count=%0d want 1 with value 0_3c3c", rx_q.size() - rx0);
        end
    endtask

    task automatic test_ramp();
        logic [15:0] adc;
        logic        ok;
        int          rx0;
        int          fe0;
        int          bad;
        rx0 = rx_q.size();
        fe0 = ferr_cnt;
        bad = 0;
        for (int v = 0; v < 8; v++) begin
            send_slot((v % 2 == 0) ? 1'b1 : 1'b0, 16'(v), 32, adc, ok);
        end
        tests_run++;
        if (rx_q.size() != rx0 + 8) begin
            tests_failed++;
            $display("[TB] FAIL ramp_count got %0d want 8", rx_q.size() - rx0);
        end else begin
            for (int v = 0; v < 8; v++) begin
                if (rx_q[rx0+v] !== {((v % 2 == 0) ? 1'b1 : 1'b0), 16'(v)}) bad++;
            end
            tests_run++;
            if (bad != 0) begin
                tests_failed++;
                $display("[TB] FAIL ramp_values got %0d wrong samples want 0", bad);
            end
        end
        tests_run++;
        if (ferr_cnt != fe0) begin
            tests_failed++;
            $display("[TB] FAIL ramp_frame_err got %0d want 0", ferr_cnt - fe0);
        end
    endtask

    initial begin
        reset          = 1'b0;
        bus.AUD_BCLK   = 1'b0;
        bus.AUD_LRCK   = 1'b0;
        bus.AUD_DACDAT = 1'b0;
        tx_data        = '0;
        tx_chan        = 1'b0;
        tx_valid       = 1'b0;
        @(negedge clk);
        test_reset();
        test_playback();
        test_capture();
        test_underrun();
        test_short_slot();
        test_ramp();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
